imm_encode: RTL and testbench

Inverse of the core's immediate extender. Takes a 32-bit immediate value plus the same 3-bit `immsrc` format code and packs it into instruction bits [31:7]. It also reports whether the value is representable in that format. The block sits in the instruction-memory loader / debug patch path and builds instruction words that the extender will later decode back to the identical value. It is a 2-stage valid/ready pipeline with throughput of one request per cycle.

---
 rtl/imm_encode_pkg.sv | 40 ++++
 rtl/imm_encode_fmt.sv | 71 +++++++
 rtl/imm_encode.sv | 112 +++++++++++
 tb/tb_imm_encode.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_encode_pkg.sv
// imm_encode_pkg: format codes and constant tables shared by the immediate
// extender and the immediate encoder (imm_encode).
package imm_encode_pkg;

    // Immediate format codes carried on immsrc; codes 3'b11x are reserved.
    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_LUI = 3'b010,
        IMM_IU  = 3'b011,
        IMM_B   = 3'b100,
        IMM_F   = 3'b101
    } imm_src_e;

    // Floating-point constants selectable by the 3-bit F index at instr[26:24].
    localparam int F_TABLE_DEPTH = 8;
    localparam logic [31:0] F_TABLE [F_TABLE_DEPTH] = '{
        32'h0000_0000,
        32'h3C23_D70A,
        32'hBF80_0000,
        32'hBE4C_CCCD,
        32'hBDCC_CCCD,
        32'h4CBE_BC20,
        32'h4316_0000,
        32'hC316_0000
    };

    // The only two values the B format can express; rs2_1 selects 99.
    localparam logic [31:0] B_CONST_LO = 32'd2;
    localparam logic [31:0] B_CONST_HI = 32'd99;

    // Width of the optional statistics counters.
    localparam int STAT_W = 16;

    // True when a 32-bit value is the sign extension of its low 12 bits.
    function automatic logic fits_simm12(input logic [31:0] imm);
        return (imm[31:11] == '0) || (imm[31:11] == '1);
    endfunction

endpackage

// File: rtl/imm_encode_fmt.sv
// imm_encode_fmt: combinational encode of one immediate into instruction
// bits [31:7]. Index i of base/instr corresponds to instruction bit i+7.
module imm_encode_fmt
    import imm_encode_pkg::*;
(
    input  logic [31:0] imm,
    input  logic [2:0]  immsrc,
    input  logic [24:0] base,
    output logic [24:0] instr,
    output logic        rs2_1,
    output logic        fits
);

    logic       f_hit;
    logic [2:0] f_idx;

    // Search the F constant table; entries are distinct so at most one hits.
    always_comb begin
        f_hit = 1'b0;
        f_idx = '0;
        for (int k = 0; k < F_TABLE_DEPTH; k++) begin
            if (imm == F_TABLE[k]) begin
                f_hit = 1'b1;
                f_idx = 3'(k);
            end
        end
    end

    // Overwrite the immediate fields of base; truncated fields are still
    // written when the value does not fit, only fits reports the loss.
    always_comb begin
        instr = base;
        rs2_1 = 1'b0;
        fits  = 1'b0;
        case (immsrc)
            IMM_I: begin
                instr[24:13] = imm[11:0];             // instr[31:20]
                fits         = fits_simm12(imm);
            end
            IMM_S: begin
                instr[24:18] = imm[11:5];             // instr[31:25]
                instr[4:0]   = imm[4:0];              // instr[11:7]
                fits         = fits_simm12(imm);
            end
            IMM_LUI: begin
                instr[24:5] = imm[31:12];             // instr[31:12]
                fits        = (imm[11:0] == '0);
            end
            IMM_IU: begin
                instr[24:13] = imm[11:0];             // instr[31:20]
                fits         = (imm[31:12] == '0);
            end
            IMM_B: begin
                rs2_1 = (imm == B_CONST_HI);
                fits  = (imm == B_CONST_LO) || (imm == B_CONST_HI);
            end
            IMM_F: begin
                if (f_hit) begin
                    instr[19:17] = f_idx;             // instr[26:24]
                end
                fits = f_hit;
            end
            default: begin
                instr = base;
                rs2_1 = 1'b0;
                fits  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_encode.sv
// imm_encode: two-stage pipelined immediate encoder (inverse of the
// immediate extender). Optional statistics counters are built when the
// macro IMM_ENCODE_STATS_EN is defined.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and its payload stable until the
// transfer; ready may be asserted without valid. in_ready does not depend
// on in_valid, and out_* hold stable while out_valid && !out_ready.
module imm_encode
    import imm_encode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_immsrc,
    input  logic [31:0] in_imm,
    input  logic [24:0] in_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] out_instr,
    output logic        out_rs2_1,
    output logic        out_fits
`ifdef IMM_ENCODE_STATS_EN
    ,
    output logic [15:0] stat_total,
    output logic [15:0] stat_miss
`endif
);

    logic        s1_valid;
    logic [2:0]  s1_immsrc;
    logic [31:0] s1_imm;
    logic [24:0] s1_base;

    logic        s1_en;
    logic        s2_en;

    logic [24:0] enc_instr;
    logic        enc_rs2_1;
    logic        enc_fits;

    // Stage enables: a stage advances when it is empty or its consumer moves.
    always_comb begin
        s2_en    = !out_valid || out_ready;
        s1_en    = !s1_valid || s2_en;
        in_ready = s1_en;
    end

    // Stage 1: capture the raw request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_immsrc <= '0;
            s1_imm    <= '0;
            s1_base   <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_immsrc <= in_immsrc;
                s1_imm    <= in_imm;
                s1_base   <= in_base;
            end
        end
    end

    imm_encode_fmt u_fmt (
        .imm    (s1_imm),
        .immsrc (s1_immsrc),
        .base   (s1_base),
        .instr  (enc_instr),
        .rs2_1  (enc_rs2_1),
        .fits   (enc_fits)
    );

    // Stage 2: register the encoded result directly onto the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_rs2_1 <= 1'b0;
            out_fits  <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= enc_instr;
                out_rs2_1 <= enc_rs2_1;
                out_fits  <= enc_fits;
            end
        end
    end

`ifdef IMM_ENCODE_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // Saturating counts of delivered results and of unrepresentable ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_total <= '0;
            stat_miss  <= '0;
        end else if (out_valid && out_ready) begin
            if (stat_total != STAT_MAX) begin
                stat_total <= stat_total + 16'd1;
            end
            if (!out_fits && (stat_miss != STAT_MAX)) begin
                stat_miss <= stat_miss + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imm_encode.sv
// tb_imm_encode: directed and randomized checks of imm_encode against a
// behavioural model written in terms of full 32-bit instruction words.
module tb_imm_encode;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_immsrc;
    logic [31:0] in_imm;
    logic [24:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_instr;
    logic        out_rs2_1;
    logic        out_fits;
`ifdef IMM_ENCODE_STATS_EN
    logic [15:0] stat_total;
    logic [15:0] stat_miss;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    int tb_hs   = 0;
    int tb_miss = 0;

    logic [26:0] exp_q[$];
    int          acc_q[$];

    logic [31:0] f_vals [0:7] = '{
        32'h00000000, 32'h3C23D70A, 32'hBF800000, 32'hBE4CCCCD,
        32'hBDCCCCCD, 32'h4CBEBC20, 32'h43160000, 32'hC3160000
    };

    imm_encode dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_immsrc (in_immsrc),
        .in_imm    (in_imm),
        .in_base   (in_base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_rs2_1 (out_rs2_1),
        .out_fits  (out_fits)
`ifdef IMM_ENCODE_STATS_EN
        ,
        .stat_total(stat_total),
        .stat_miss (stat_miss)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Reference: build the full instruction word, then return {word[31:7], rs2_1, fits}.
    function automatic logic [26:0] model(input logic [2:0] src, input logic [31:0] imm,
                                          input logic [24:0] base);
        logic [31:0] w;
        logic        rs2;
        logic        ok;
        w   = {base, 7'd0};
        rs2 = 1'b0;
        ok  = 1'b0;
        case (src)
            3'd0: begin
                w[31:20] = imm[11:0];
                ok = ($signed(imm) >= -2048) && ($signed(imm) <= 2047);
            end
            3'd1: begin
                w[31:25] = imm[11:5];
                w[11:7]  = imm[4:0];
                ok = ($signed(imm) >= -2048) && ($signed(imm) <= 2047);
            end
            3'd2: begin
                w[31:12] = imm[31:12];
                ok = ((imm % 4096) == 0);
            end
            3'd3: begin
                w[31:20] = imm[11:0];
                ok = (imm < 4096);
            end
            3'd4: begin
                rs2 = (imm == 99);
                ok  = (imm == 2) || (imm == 99);
            end
            3'd5: begin
                for (int k = 0; k < 8; k++) begin
                    if (imm == f_vals[k]) begin
                        w[26:24] = k[2:0];
                        ok = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        return {w[31:7], rs2, ok};
    endfunction

    function automatic logic [31:0] rand_imm();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: v = $urandom;
            1: v = 32'($urandom_range(0, 4095)) - 32'd2048;
            2: v = f_vals[$urandom_range(0, 7)];
            3: v = ($urandom_range(0, 1) == 1) ? 32'd99 : 32'd2;
            default: v = $urandom & 32'hFFFFF000;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated request with out_ready high; checks latency 2 and contents.
    task automatic do_one(input string tag, input logic [2:0] src, input logic [31:0] imm,
                          input logic [24:0] base);
        logic [26:0] e;
        e = model(src, imm, base);
        @(negedge clk);
        in_valid  = 1'b1;
        in_immsrc = src;
        in_imm    = imm;
        in_base   = base;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'({out_instr, out_rs2_1, out_fits}), 32'(e));
        tb_hs++;
        if (!e[0]) tb_miss++;
    endtask

    // Stream n items; random_ready toggles out_ready, otherwise latency must be exactly 2.
    task automatic run_stream(input int n_items, input bit random_ready);
        int          sent = 0;
        int          got = 0;
        int          budget = 0;
        bit          pending = 0;
        logic        stall_prev = 1'b0;
        logic [26:0] held = '0;
        logic [26:0] e;
        int          a;
        while ((sent < n_items || got < n_items) && budget < 600) begin
            @(negedge clk);
            cycle++;
            budget++;
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'({out_instr, out_rs2_1, out_fits}), 32'(held));
            end
            out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < n_items) begin
                if (!pending) begin
                    in_immsrc = 3'($urandom_range(0, 7));
                    in_imm    = rand_imm();
                    in_base   = 25'($urandom);
                    pending   = 1;
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_immsrc, in_imm, in_base));
                acc_q.push_back(cycle);
                sent++;
                pending = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("stream_data", 32'({out_instr, out_rs2_1, out_fits}), 32'(e));
                    if (!random_ready) check("stream_latency", 32'(cycle - a), 32'd2);
                    got++;
                    tb_hs++;
                    if (!e[0]) tb_miss++;
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_instr, out_rs2_1, out_fits};
        end
        check("stream_count", 32'(got), 32'(n_items));
        check("stream_queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    // Main sequence
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_immsrc = '0;
        in_imm    = '0;
        in_base   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", 32'(out_instr), 32'd0);
        check("rst_out_rs2_1", 32'(out_rs2_1), 32'd0);
        check("rst_out_fits", 32'(out_fits), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef IMM_ENCODE_STATS_EN
        check("rst_stat_total", 32'(stat_total), 32'd0);
        check("rst_stat_miss", 32'(stat_miss), 32'd0);
`endif
        reset = 1'b0;

        // I format boundaries
        do_one("i_neg", 3'd0, 32'hFFFFF800, 25'd0);
        check("i_neg_field", 32'(out_instr[24:13]), 32'h800);
        check("i_neg_fits", 32'(out_fits), 32'd1);
        do_one("i_pos_over", 3'd0, 32'h00000800, 25'd0);
        check("i_pos_over_fits", 32'(out_fits), 32'd0);

        // LUI with rd preserved
        do_one("lui", 3'd2, 32'h12345000, 25'd5);
        check("lui_field", 32'(out_instr[24:5]), 32'h12345);
        check("lui_rd", 32'(out_instr[4:0]), 32'd5);
        check("lui_fits", 32'(out_fits), 32'd1);
        do_one("lui_low", 3'd2, 32'h12345001, 25'd5);
        check("lui_low_fits", 32'(out_fits), 32'd0);

        // F table
        do_one("f_hit", 3'd5, 32'h43160000, 25'd0);
        check("f_idx", 32'(out_instr[19:17]), 32'd6);
        check("f_hit_fits", 32'(out_fits), 32'd1);
        do_one("f_negzero", 3'd5, 32'h80000000, 25'd0);
        check("f_negzero_fits", 32'(out_fits), 32'd0);

        // B constants
        do_one("b99", 3'd4, 32'd99, 25'h1ABCDE);
        check("b99_rs2", 32'(out_rs2_1), 32'd1);
        check("b99_fits", 32'(out_fits), 32'd1);
        do_one("b2", 3'd4, 32'd2, 25'h1ABCDE);
        check("b2_rs2", 32'(out_rs2_1), 32'd0);
        check("b2_fits", 32'(out_fits), 32'd1);
        do_one("b3", 3'd4, 32'd3, 25'h1ABCDE);
        check("b3_fits", 32'(out_fits), 32'd0);

        // S, I-unsigned and reserved
        do_one("s_mix", 3'd1, 32'hFFFFF9A5, 25'h0F0F0F);
        do_one("iu_max", 3'd3, 32'h00000FFF, 25'h155555);
        do_one("iu_over", 3'd3, 32'h00001000, 25'h155555);
        do_one("rsv6", 3'd6, 32'hDEADBEEF, 25'h0ABCDE);
        check("rsv6_instr", 32'(out_instr), 32'h0ABCDE);
        do_one("rsv7", 3'd7, 32'd99, 25'h1FFFFFF);

        // Streaming: random backpressure, then unstalled latency
        run_stream(20, 1'b1);
        run_stream(8, 1'b0);

`ifdef IMM_ENCODE_STATS_EN
        check("stat_total", 32'(stat_total), 32'(tb_hs));
        check("stat_miss", 32'(stat_miss), 32'(tb_miss));
`endif

        // Fill both stages, then reset mid-flight
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'b1;
            in_immsrc = 3'd0;
            in_imm    = 32'(i + 1);
            in_base   = 25'($urandom);
            #1;
            check("fill_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_instr", 32'(out_instr), 32'd0);
`ifdef IMM_ENCODE_STATS_EN
        check("midrst_stat_total", 32'(stat_total), 32'd0);
        check("midrst_stat_miss", 32'(stat_miss), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("post_rst_out_valid2", 32'(out_valid), 32'd0);
        do_one("recover", 3'd0, 32'h000007FF, 25'h0000A5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
